// File: rtl/mem_image_loader_pkg.sv
// Shared types and default parameters for the program-image loader.
// State codes are fixed so they stay stable across tools and debug views.
package mem_image_loader_pkg;

  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_RUN_CYCLES = 10000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_ZERO_FILL = 3'd2,
    ST_RUN       = 3'd3,
    ST_DONE      = 3'd4
  } loader_state_e;

endpackage

// File: rtl/mem_image_loader_if.sv
// Image stream (valid/ready) and memory write port of the loader.
// master = loader side, slave = image source / memory side.
interface mem_image_loader_if
  import mem_image_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_image_loader_counter.sv
// Loadable, clearable, enabled up-counter used for the write pointer and run-cycle count.
// Priority: clr over load over en.
module mem_image_loader_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)       count_d = '0;
    else if (load) count_d = load_val;
    else if (en)   count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/mem_image_loader.sv
// Streams a program image into cpu memory, zero-fills the tail while holding the cpu in reset,
// then runs the cpu for RUN_CYCLES clock-enabled cycles and freezes it for inspection.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start after reset, cpu held in reset
// LOAD      | accepting image words, one write per handshake
// ZERO_FILL | writing zeros from ptr up to DEPTH-1
// RUN       | cpu released and clock-enabled, cycles counting
// DONE      | cpu frozen (enable low, reset low), waiting for restart
module mem_image_loader
  import mem_image_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RUN_CYCLES = DEF_RUN_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_WIDTH:0] word_count,
  mem_image_loader_if.master  bus,
  output logic                cpu_reset,
  output logic                cpu_en,
  output logic                busy,
  output logic                done,
  output logic [31:0]         cycles
);
  localparam logic [ADDR_WIDTH:0] DEPTH_W   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [31:0]         RUN_LAST  = 32'(RUN_CYCLES - 1);

  loader_state_e state_q, state_d;

  logic [ADDR_WIDTH:0]   n_q, n_d;
  logic                  in_ready_q, in_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  cpu_en_q, cpu_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [ADDR_WIDTH:0] ptr_q;
  logic [31:0]         cycles_q;
  logic [ADDR_WIDTH:0] wc_clamped;
  logic                start_acc, xfer, last_word, zero_fill, run_last;

  assign wc_clamped = (word_count > DEPTH_W) ? DEPTH_W : word_count;
  assign start_acc  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign xfer       = (state_q == ST_LOAD) && bus.in_valid && in_ready_q;
  assign last_word  = xfer && ((ptr_q + 1'b1) == n_q);
  assign zero_fill  = (state_q == ST_ZERO_FILL);
  assign run_last   = (state_q == ST_RUN) && (cycles_q == RUN_LAST);

  mem_image_loader_counter #(.WIDTH(ADDR_WIDTH + 1)) u_ptr (
    .clk      (clk),
    .reset    (reset),
    .clr      (start_acc),
    .load     (1'b0),
    .load_val ('0),
    .en       (xfer || zero_fill),
    .count    (ptr_q)
  );

  mem_image_loader_counter #(.WIDTH(32)) u_cycles (
    .clk      (clk),
    .reset    (reset),
    .clr      (start_acc),
    .load     (1'b0),
    .load_val ('0),
    .en       (state_q == ST_RUN),
    .count    (cycles_q)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) state_d = (wc_clamped == '0) ? ST_ZERO_FILL : ST_LOAD;
      end
      ST_LOAD: begin
        if (last_word) state_d = (n_q < DEPTH_W) ? ST_ZERO_FILL : ST_RUN;
      end
      ST_ZERO_FILL: begin
        if (ptr_q == LAST_ADDR) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (run_last) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Flag outputs follow the next state so they change on the same edge as the state.
  always_comb begin
    n_d         = start_acc ? wc_clamped : n_q;
    in_ready_d  = (state_d == ST_LOAD);
    mem_we_d    = xfer || zero_fill;
    mem_addr_d  = mem_we_d ? ptr_q[ADDR_WIDTH-1:0] : mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (xfer)           mem_wdata_d = bus.in_data;
    else if (zero_fill) mem_wdata_d = '0;
    cpu_en_d    = (state_d == ST_RUN);
    cpu_reset_d = !((state_d == ST_RUN) || (state_d == ST_DONE));
    busy_d      = (state_d == ST_LOAD) || (state_d == ST_ZERO_FILL) || (state_d == ST_RUN);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_q         <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      cpu_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      n_q         <= n_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      cpu_en_q    <= cpu_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_reset     = cpu_reset_q;
  assign cpu_en        = cpu_en_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign cycles        = cycles_q;
endmodule

// File: tb/tb_mem_image_loader.sv
// Randomized scoreboard bench for mem_image_loader (16-word memory, 8 run cycles).
// Expected memory writes are queued at start and consumed by an independent monitor.
module tb_mem_image_loader;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int RUNC  = 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   word_count;
  logic          cpu_reset, cpu_en, busy, done;
  logic [31:0]   cycles;

  mem_image_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_image_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RUN_CYCLES(RUNC)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .bus        (bus),
    .cpu_reset  (cpu_reset),
    .cpu_en     (cpu_en),
    .busy       (busy),
    .done       (done),
    .cycles     (cycles)
  );

  always #10 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [DW-1:0] image [32];
  int          idx, accepted, offer_n, mode, run_en_cnt, exp_n;
  logic        will_xfer;
  logic        v;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent monitor: every presented write must be the next one the model predicts.
  always @(negedge clk) begin
    if (bus.mem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", 64'(bus.mem_addr), 64'(mon_e.addr));
        check("write_data", 64'(bus.mem_wdata), 64'(mon_e.data));
      end
    end
    if (cpu_en) begin
      run_en_cnt++;
      check("run_flags", {61'd0, cpu_reset, busy, done}, 64'b010);
    end
  end

  // One clock of stimulus: account for the handshake just taken, then offer the next word.
  task automatic tick();
    @(negedge clk);
    if (will_xfer) begin
      idx++;
      accepted++;
    end
    if (idx < offer_n) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = !bus.in_valid;
        default: v = 1'($urandom_range(0, 1));
      endcase
    end else begin
      v = 1'b0;
    end
    bus.in_valid = v;
    bus.in_data  = v ? image[idx] : $urandom;
    will_xfer    = v && bus.in_ready;
  endtask

  task automatic do_start(input int wc, input int offer, input int md);
    idx       = 0;
    accepted  = 0;
    offer_n   = offer;
    mode      = md;
    will_xfer = 1'b0;
    exp_n     = (wc > DEPTH) ? DEPTH : wc;
    for (int a = 0; a < DEPTH; a++)
      exp_q.push_back('{addr: AW'(a), data: (a < exp_n) ? image[a] : '0});
    run_en_cnt = 0;
    start      = 1'b1;
    word_count = (AW+1)'(wc);
    tick();
    start      = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_cpu_reset", 64'(cpu_reset), 64'd1);
    check("start_in_ready", 64'(bus.in_ready), 64'(exp_n > 0));
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 600 && !done; i++) tick();
    if (!done) $display("FAIL %s_timeout: got done=0 expected done=1 within 600 cycles", name);
    check({name, "_done"}, 64'(done), 64'd1);
    check({name, "_cycles"}, 64'(cycles), 64'(RUNC));
    check({name, "_run_len"}, 64'(run_en_cnt), 64'(RUNC));
    check({name, "_accepted"}, 64'(accepted), 64'(exp_n));
    check({name, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_cpu_reset"}, 64'(cpu_reset), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic fill_image();
    for (int i = 0; i < 32; i++) image[i] = $urandom;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; word_count = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    idx = 0; accepted = 0; offer_n = 0; mode = 0; run_en_cnt = 0; will_xfer = 1'b0; exp_n = 0;
    fill_image();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tick();
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    check("rst_cpu", {62'd0, cpu_reset, cpu_en}, 64'b10);
    check("rst_busy_done", {62'd0, busy, done}, 64'b00);
    check("rst_cycles", 64'(cycles), 64'd0);

    // basic three-word image, valid held high
    image[0] = 32'hAA; image[1] = 32'hBB; image[2] = 32'hCC;
    do_start(3, 3, 0);
    wait_done("t1");

    // valid toggling every other cycle
    fill_image();
    do_start(7, 7, 1);
    wait_done("t2");

    // oversize count clamps to depth, surplus words refused
    fill_image();
    do_start(20, 20, 0);
    wait_done("t3");

    // empty image, start during RUN ignored, DONE holds
    do_start(0, 0, 0);
    for (int i = 0; i < 100 && !cpu_en; i++) tick();
    check("t4_run_reached", 64'(cpu_en), 64'd1);
    start = 1'b1; word_count = 5'd5;
    tick();
    start = 1'b0;
    wait_done("t4");
    repeat (3) tick();
    check("t4_hold_cycles", 64'(cycles), 64'(RUNC));
    check("t4_hold_done", {62'd0, done, cpu_en}, 64'b10);

    // reset in the second LOAD cycle, then full reload
    fill_image();
    do_start(5, 5, 0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_mem_we", 64'(bus.mem_we), 64'd0);
    check("t5_cpu_reset", 64'(cpu_reset), 64'd1);
    check("t5_done_busy", {62'd0, done, busy}, 64'b00);
    check("t5_in_ready", 64'(bus.in_ready), 64'd0);
    exp_q.delete();
    offer_n = 0;
    tick();
    fill_image();
    do_start(9, 9, 2);
    wait_done("t5_reload");

    // randomized loads
    for (int r = 0; r < 4; r++) begin
      int wc;
      wc = $urandom_range(0, 20);
      fill_image();
      do_start(wc, wc, $urandom_range(0, 2));
      wait_done("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
